// File: rtl/eeprom_const_ctrl.sv
// Read sequencer for the SHA-256 constant EEPROM: serves 8-word H bursts and
// single K[t] fetches, generating CE_N/OE_N with a programmable access wait.
module eeprom_const_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned H_BASE      = 0,
    parameter int unsigned K_BASE      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        H_REQ,
    input  logic        K_REQ,
    input  logic [5:0]  K_IDX,
    output logic        BUSY,
    output logic        DVALID,
    output logic        DKIND,
    output logic [5:0]  DIDX,
    output logic [31:0] DOUT,
    output logic        DONE_H,
    output logic [12:0] EE_A,
    input  logic [31:0] EE_IO,
    output logic        EE_CE_N,
    output logic        EE_OE_N,
    output logic        EE_WE_N,
    output logic [1:0]  DBG_STATE
);

    // Handshake: H_REQ/K_REQ are sampled only while IDLE (BUSY=0) and are never
    // queued; DVALID is a one-cycle strobe with no backpressure from the consumer.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [12:0] H_BASE_A  = 13'(H_BASE);
    localparam logic [12:0] K_BASE_A  = 13'(K_BASE);
    localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        kind, kind_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [7:0]  wait_cnt;
    logic [12:0] addr_nxt;

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (H_REQ) begin
                    kind_nxt  = 1'b0;
                    idx_nxt   = 6'd0;
                    state_nxt = SETUP;
                end else if (K_REQ) begin
                    kind_nxt  = 1'b1;
                    idx_nxt   = K_IDX;
                    state_nxt = SETUP;
                end
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (wait_cnt == 8'd0) state_nxt = RELEASE;
            end
            RELEASE: begin
                // An H burst goes straight back to SETUP so BUSY never drops mid-burst.
                if (!kind && idx < 6'd7) begin
                    idx_nxt   = idx + 6'd1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_nxt = (kind_nxt ? K_BASE_A : H_BASE_A) + {7'd0, idx_nxt};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            kind     <= 1'b0;
            idx      <= 6'd0;
            wait_cnt <= 8'd0;
            EE_A     <= 13'd0;
            DOUT     <= 32'd0;
            DKIND    <= 1'b0;
            DIDX     <= 6'd0;
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
            idx   <= idx_nxt;
            // Address is set up one cycle ahead of CE_N and held through ACCESS.
            if (state_nxt == SETUP) EE_A <= addr_nxt;
            if (state == SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ACCESS && wait_cnt != 8'd0) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
            if (state == ACCESS && wait_cnt == 8'd0) begin
                DOUT  <= EE_IO;
                DKIND <= kind;
                DIDX  <= idx;
            end
        end
    end

    assign BUSY      = (state != IDLE);
    assign EE_CE_N   = (state != ACCESS);
    assign EE_OE_N   = (state != ACCESS);
    assign EE_WE_N   = 1'b1;
    assign DVALID    = (state == RELEASE);
    assign DONE_H    = (state == RELEASE) && !kind && (idx == 6'd7);
    assign DBG_STATE = state;

endmodule
